// File: rtl/ntt_vec_ctrl_pkg.sv
// ntt_vec_ctrl_pkg
//   Shared constants for the NTT vector controller: polynomial length,
//   coefficient and address widths, WAIT time-out length and FSM state
//   encodings.
package ntt_vec_ctrl_pkg;

    localparam int KYBER_N     = 256;
    localparam int COEF_W      = 12;
    localparam int ADDR_W      = 8;
    localparam int POLY_W      = 3;
    localparam int TIMEOUT_CYC = 4;

    localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(KYBER_N - 1);

    localparam int STATE_W = 3;

    // State encodings (legacy-compatible constants).
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_START = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD    = 3'd4;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd5;
    localparam logic [STATE_W-1:0] ST_NEXT  = 3'd6;

endpackage

// File: rtl/ntt_vec_ctrl.sv
// ntt_vec_ctrl
//   Sequences a vector of cmd_k polynomials through an external NTT engine:
//   for each polynomial it streams 256 coefficients into the engine RAM,
//   pulses eng_start, waits for eng_done, then streams the 256 results out.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_mode, cmd_k)
//   in_valid/in_ready/in_data       coefficient load stream
//   out_valid/out_ready/out_data    result stream, out_last on the final
//                                   coefficient of the final polynomial
//   eng_start/eng_mode              engine kick-off and direction
//   eng_done/eng_busy               engine status
//   eng_we/eng_addr/eng_din/eng_dout engine coefficient RAM port
//   busy, err                       command in progress / error pulse
//   dbg_state                       current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and its payload steady until that edge,
// and ready never depends on valid of the same channel.
module ntt_vec_ctrl
    import ntt_vec_ctrl_pkg::*;
#(
    parameter int MAX_K = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_mode,
    input  logic [2:0]           cmd_k,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COEF_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COEF_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 eng_start,
    output logic                 eng_mode,
    input  logic                 eng_done,
    input  logic                 eng_busy,
    output logic                 eng_we,
    output logic [ADDR_W-1:0]    eng_addr,
    output logic [COEF_W-1:0]    eng_din,
    input  logic [COEF_W-1:0]    eng_dout,
    output logic                 busy,
    output logic                 err,
    output logic [STATE_W-1:0]   dbg_state
);

    localparam logic [POLY_W-1:0] MAX_K_W   = POLY_W'(MAX_K);
    localparam logic [1:0]        TO_LAST   = 2'(TIMEOUT_CYC - 1);

    logic [STATE_W-1:0] state_q,    state_d;
    logic               mode_q,     mode_d;
    logic [POLY_W-1:0]  k_q,        k_d;
    logic [POLY_W-1:0]  poly_q,     poly_d;
    logic [ADDR_W-1:0]  coef_q,     coef_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic               hold_new_q, hold_new_d;
    logic [COEF_W-1:0]  out_data_q, out_data_d;
    logic               err_q,      err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            k_q        <= '0;
            poly_q     <= '0;
            coef_q     <= '0;
            wait_cnt_q <= '0;
            hold_new_q <= 1'b0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            k_q        <= k_d;
            poly_q     <= poly_d;
            coef_q     <= coef_d;
            wait_cnt_q <= wait_cnt_d;
            hold_new_q <= hold_new_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        k_d        = k_q;
        poly_d     = poly_q;
        coef_d     = coef_q;
        wait_cnt_d = wait_cnt_q;
        hold_new_d = 1'b0;
        out_data_d = out_data_q;
        err_d      = 1'b0;

        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        eng_we     = 1'b0;
        eng_addr   = '0;
        eng_din    = '0;
        eng_start  = 1'b0;
        eng_mode   = 1'b0;
        out_valid  = 1'b0;
        out_data   = out_data_q;
        out_last   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Illegal counts are consumed but only raise err.
                    if ((cmd_k == '0) || (cmd_k > MAX_K_W)) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = cmd_mode;
                        k_d     = cmd_k;
                        poly_d  = '0;
                        coef_d  = '0;
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                in_ready = 1'b1;
                eng_addr = coef_q;
                eng_we   = in_valid;
                eng_din  = in_data;
                if (in_valid) begin
                    coef_d = coef_q + 1'b1;   // wraps to 0 after the last one
                    if (coef_q == LAST_COEF) begin
                        state_d = ST_START;
                    end
                end
            end

            ST_START: begin
                eng_start  = 1'b1;
                eng_mode   = mode_q;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (eng_done) begin
                    wait_cnt_d = '0;
                    state_d    = ST_RD;
                end else if (!eng_busy) begin
                    // An engine that is neither busy nor done for
                    // TIMEOUT_CYC cycles in a row is treated as dead.
                    if (wait_cnt_q == TO_LAST) begin
                        wait_cnt_d = '0;
                        err_d      = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end

            ST_RD: begin
                eng_addr   = coef_q;
                hold_new_d = 1'b1;
                state_d    = ST_HOLD;
            end

            ST_HOLD: begin
                out_valid = 1'b1;
                // The RAM word addressed in RD arrives during the first HOLD
                // cycle; it is shown directly then and captured, because the
                // RAM output moves on once eng_addr returns to 0.
                if (hold_new_q) begin
                    out_data   = eng_dout;
                    out_data_d = eng_dout;
                end
                out_last = (coef_q == LAST_COEF) && (poly_q == k_q - 1'b1);
                if (out_ready) begin
                    coef_d  = coef_q + 1'b1;
                    state_d = (coef_q == LAST_COEF) ? ST_NEXT : ST_RD;
                end
            end

            ST_NEXT: begin
                poly_d = poly_q + 1'b1;
                if (poly_q + 1'b1 == k_q) begin
                    state_d = ST_IDLE;
                end else begin
                    coef_d  = '0;
                    state_d = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
